// File: rtl/muon_report_pkg.sv
// Shared definitions for the muon report transmitter.
//   - ASCII constants used to build the report line
//   - FRAME_LEN for the plain (29-byte) and checksummed (32-byte) frames
//   - byte-FSM state enum shared by the top and the bit serialiser
//   - helpers: nibble -> ASCII digit, nibble -> uppercase hex, frame byte lookup
// Optional feature macro: REPORT_CHECKSUM_EN (appends "*HH" before CR LF).
package muon_report_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  // "A:dddd B:dddd C:dddd D:dddd" - the part covered by the checksum
  localparam int DATA_LEN        = 27;
  localparam int FRAME_LEN_PLAIN = 29;
  localparam int FRAME_LEN_CSUM  = 32;
`ifdef REPORT_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  // BCD nibble to ASCII digit; values above 9 are not BCD and print as '?'
  function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_ZERO + {4'd0, n}) : ASCII_QMARK;
  endfunction

  // Nibble to uppercase hex digit (0x37 + 10 = 'A')
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_ZERO + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  // Byte idx (0..26) of the data part; snap = {A, B, C, D}.
  // Each field is 7 bytes: letter, ':', four digits, ' ' (the last space
  // position of field D falls at index 27 and is never requested here).
  function automatic logic [7:0] field_byte(input logic [4:0] idx, input logic [63:0] snap);
    logic [1:0]  field;
    logic [2:0]  pos;
    logic [15:0] word;
    logic [3:0]  nib;
    if (idx < 5'd7) begin
      field = 2'd0; pos = idx[2:0];
    end else if (idx < 5'd14) begin
      field = 2'd1; pos = 3'(idx - 5'd7);
    end else if (idx < 5'd21) begin
      field = 2'd2; pos = 3'(idx - 5'd14);
    end else begin
      field = 2'd3; pos = 3'(idx - 5'd21);
    end
    case (field)
      2'd0:    word = snap[63:48];
      2'd1:    word = snap[47:32];
      2'd2:    word = snap[31:16];
      default: word = snap[15:0];
    endcase
    case (pos)
      3'd2:    nib = word[15:12];
      3'd3:    nib = word[11:8];
      3'd4:    nib = word[7:4];
      default: nib = word[3:0];
    endcase
    case (pos)
      3'd0:    return ASCII_A + {6'd0, field};
      3'd1:    return ASCII_COLON;
      3'd6:    return ASCII_SPACE;
      default: return nibble_ascii(nib);
    endcase
  endfunction

endpackage

// File: rtl/muon_report_tx_uart.sv
// uart_tx_byte: 8N1 bit serialiser with its own bit timer.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   load        accept data when ready=1
//   data [7:0]  byte to send, LSB first
//   ready       idle, or in the final cycle of the stop bit (back-to-back load)
//   tx          registered serial output, idle high
module uart_tx_byte
  import muon_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [TW-1:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_q;

  // Accepting in the last stop cycle lets the next start bit follow with no gap.
  assign ready = (state == IDLE) || ((state == STOP) && (timer == TLAST));
  assign tx    = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          timer   <= '0;
          bit_idx <= 3'd0;
          if (load) begin
            shift <= data;
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (timer == TLAST) begin
            timer   <= '0;
            bit_idx <= 3'd0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == TLAST) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == TLAST) begin
            timer <= '0;
            if (load) begin
              shift <= data;
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/muon_report_tx.sv
// muon_report_tx: sends the four BCD result words as one ASCII line over UART 8N1,
//   "A:dddd B:dddd C:dddd D:dddd\r\n" (with REPORT_CHECKSUM_EN: "...D:dddd*HH\r\n").
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   start                request a frame; honoured only while busy=0
//   digits_A..digits_D   16-bit BCD words, [15:12] most significant; snapshotted on accept
//   tx                   UART serial output, idle high
//   busy                 high from the cycle after accept until frame end
//   done                 one-cycle pulse at frame end (busy already low in that cycle)
// Macro: REPORT_CHECKSUM_EN adds '*' and two hex digits (XOR of bytes 0..26).
module muon_report_tx
  import muon_report_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] digits_A,
  input  logic [15:0] digits_B,
  input  logic [15:0] digits_C,
  input  logic [15:0] digits_D,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [4:0] LAST = 5'(FRAME_LEN - 1);

  state_t      state;
  logic [4:0]  index;
  logic [63:0] snap;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  sel;
  logic [7:0]  frame_byte;
  logic        byte_load;
  logic        byte_ready;

  assign busy = busy_q;
  assign done = done_q;

  // Byte to hand the serialiser: byte 0 in LOAD, otherwise the one after the byte in flight.
  always_comb begin
    sel = (state == LOAD) ? 5'd0 : (index + 5'd1);
  end

`ifdef REPORT_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of the data part of the frame, from the snapshot.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < DATA_LEN; i++) begin
      csum = csum ^ field_byte(5'(i), snap);
    end
  end
`endif

  // Frame multiplexer: data part from the snapshot, then the line tail.
  always_comb begin
    frame_byte = ASCII_LF;
    if (sel < 5'(DATA_LEN)) begin
      frame_byte = field_byte(sel, snap);
    end else begin
`ifdef REPORT_CHECKSUM_EN
      case (sel)
        5'd27:   frame_byte = ASCII_STAR;
        5'd28:   frame_byte = hex_ascii(csum[7:4]);
        5'd29:   frame_byte = hex_ascii(csum[3:0]);
        5'd30:   frame_byte = ASCII_CR;
        default: frame_byte = ASCII_LF;
      endcase
`else
      if (sel == 5'd27) begin
        frame_byte = ASCII_CR;
      end else begin
        frame_byte = ASCII_LF;
      end
`endif
    end
  end

  // DATA here means "frame in progress, a byte is in the serialiser".
  assign byte_load = (state == LOAD) ||
                     ((state == DATA) && byte_ready && (index != LAST));

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .reset (reset),
    .load  (byte_load),
    .data  (frame_byte),
    .ready (byte_ready),
    .tx    (tx)
  );

  // Frame sequencing: accept/snapshot, byte index, busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      index  <= 5'd0;
      snap   <= 64'h0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap   <= {digits_A, digits_B, digits_C, digits_D};
            index  <= 5'd0;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          state <= DATA;
        end
        DATA: begin
          if (byte_ready) begin
            if (index == LAST) begin
              index  <= 5'd0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              index <= index + 5'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muon_report_tx.sv
// Testbench for muon_report_tx with CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// A UART receiver model decodes tx into a byte queue that is compared with
// hand-written expected lines; timing of busy/done is checked per frame.
module tb_muon_report_tx;

  localparam int CPB = 16;
`ifdef REPORT_CHECKSUM_EN
  localparam int FLEN = 32;
`else
  localparam int FLEN = 29;
`endif
  localparam int LAT = FLEN * 10 * CPB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] digits_A = 16'h0, digits_B = 16'h0, digits_C = 16'h0, digits_D = 16'h0;
  logic        tx, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int framing_err = 0;
  logic [7:0] rx_q[$];

  muon_report_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .digits_A(digits_A), .digits_B(digits_B), .digits_C(digits_C), .digits_D(digits_D),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // UART receiver: detect start bit, sample at bit centres on falling clock edges.
  initial begin : uart_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          if (tx !== 1'b1) framing_err++;
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare received bytes starting at queue offset off with the expected line.
  task automatic chk_frame(input string name, input string exp, input int off);
    int bad;
    logic [7:0] got;
    bad = -1;
    got = 8'h00;
    n_checks++;
    for (int i = 0; i < exp.len(); i++) begin
      if (off + i >= rx_q.size()) begin
        bad = i; got = 8'h00; break;
      end
      if (rx_q[off + i] !== exp[i]) begin
        bad = i; got = rx_q[off + i]; break;
      end
    end
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL %s: byte %0d got 0x%02h expected 0x%02h (received %0d bytes)",
               name, bad, got, exp[bad], rx_q.size());
    end
  endtask

  function automatic string full_frame(input string base);
    string s;
`ifdef REPORT_CHECKSUM_EN
    byte x;
    x = 8'h00;
    for (int i = 0; i < base.len(); i++) x = x ^ base[i];
    s = {base, "*", $sformatf("%02X", x), "\r\n"};
`else
    s = {base, "\r\n"};
`endif
    return s;
  endfunction

  // Issue one start, wait for done, check latency and the done cycle.
  task automatic run_frame(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    int lat;
    @(negedge clk);
    digits_A = a; digits_B = b; digits_C = c; digits_D = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_after_accept"}, busy, 1);
    lat = 0;
    while (!done && lat < 2 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_busy_in_done"}, busy, 0);
    @(posedge clk); #1;
    chk({name, "_done_width"}, done, 0);
  endtask

  typedef struct {
    logic [15:0] a, b, c, d;
    string       base;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cnt, dones, lows, first_done, second_done;
    string f;

    vecs[0] = '{16'h0123, 16'h0456, 16'h0007, 16'h0660, "A:0123 B:0456 C:0007 D:0660"};
    vecs[1] = '{16'h1A2F, 16'h9876, 16'h0000, 16'h5309, "A:1?2? B:9876 C:0000 D:5309"};
    vecs[2] = '{16'hFFFF, 16'h9999, 16'hABCD, 16'h0010, "A:???? B:9999 C:???? D:0010"};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, "A:0000 B:0000 C:0000 D:0000"};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      rx_q.delete();
      f = full_frame(vecs[v].base);
      run_frame($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
      chk($sformatf("vec%0d_rx_len", v), rx_q.size(), FLEN);
      chk_frame($sformatf("vec%0d_frame", v), f, 0);
    end

    // Mid-frame input changes and repeated start pulses are ignored
    rx_q.delete();
    @(negedge clk);
    digits_A = vecs[0].a; digits_B = vecs[0].b; digits_C = vecs[0].c; digits_D = vecs[0].d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 2 * LAT) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 20) begin
        digits_A = 16'h9999; digits_B = 16'h9999; digits_C = 16'h9999; digits_D = 16'h9999;
      end
      start = (cnt >= 40 && cnt <= 2000 && cnt % 40 == 0) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk("mid_latency", cnt, LAT);
    dones = 0; lows = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (tx !== 1'b1) lows++;
    end
    chk("mid_extra_done", dones, 0);
    chk("mid_no_second_frame", lows, 0);
    chk("mid_rx_len", rx_q.size(), FLEN);
    chk_frame("mid_frame", full_frame(vecs[0].base), 0);

    // Reset 1000 cycles into a frame, then a clean frame
    @(negedge clk);
    digits_A = vecs[1].a; digits_B = vecs[1].b; digits_C = vecs[1].c; digits_D = vecs[1].d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("rst_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    dones = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("rst_no_done", dones, 0);
    rx_q.delete();
    run_frame("after_rst", vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d);
    chk("after_rst_rx_len", rx_q.size(), FLEN);
    chk_frame("after_rst_frame", full_frame(vecs[0].base), 0);

    // Start held high: back-to-back frames, new accept on each done cycle
    rx_q.delete();
    @(negedge clk);
    digits_A = vecs[2].a; digits_B = vecs[2].b; digits_C = vecs[2].c; digits_D = vecs[2].d;
    start = 1'b1;
    @(posedge clk); #1;
    cnt = 0; dones = 0; first_done = 0; second_done = 0;
    while (dones < 2 && cnt < 3 * LAT) begin
      @(posedge clk); #1;
      cnt++;
      if (done) begin
        dones++;
        chk("b2b_busy_in_done", busy, 0);
        chk("b2b_tx_in_done", tx, 1);
        if (dones == 1) first_done = cnt;
        if (dones == 2) begin
          second_done = cnt;
          start = 1'b0;
        end
      end else if (dones == 1 && cnt == first_done + 1) begin
        chk("b2b_reaccept_busy", busy, 1);
        chk("b2b_tx_in_load", tx, 1);
      end
    end
    start = 1'b0;
    chk("b2b_first_done", first_done, LAT);
    chk("b2b_second_done", second_done, 2 * LAT + 1);
    @(posedge clk); #1;
    chk("b2b_idle_after", busy, 0);
    chk("b2b_rx_len", rx_q.size(), 2 * FLEN);
    chk_frame("b2b_frame0", full_frame(vecs[2].base), 0);
    chk_frame("b2b_frame1", full_frame(vecs[2].base), FLEN);

    chk("framing_errors", framing_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
